// File: rtl/microondas_timer_ctrl_if.sv
// rtl/microondas_timer_ctrl_if.sv - keypad/door/tick inputs and display/magnetron outputs of the microwave timer
interface microondas_timer_ctrl_if;
    logic       tick;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_open;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       magnetron_on;
    logic       done;
    logic [2:0] state;

    modport master (
        output tick, key_valid, key_digit, start, stop_clear, door_open,
        input  sec_units, sec_tens, min_units, min_tens, magnetron_on, done, state
    );

    modport slave (
        input  tick, key_valid, key_digit, start, stop_clear, door_open,
        output sec_units, sec_tens, min_units, min_tens, magnetron_on, done, state
    );
endinterface

// File: rtl/microondas_timer_ctrl.sv
// rtl/microondas_timer_ctrl.sv - MM:SS BCD countdown controller with keypad entry, pause, quick start and timed done
module microondas_timer_ctrl #(
    parameter int DONE_TICKS = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    microondas_timer_ctrl_if.slave   io_ctrl
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LP_DONE_TICKS = 4'(DONE_TICKS);

    state_t     r_state;
    logic [3:0] r_su, r_st, r_mu, r_mt;
    logic [3:0] r_done_cnt;
    logic       r_mag;
    logic       r_done;

    state_t     w_nstate;
    logic [3:0] w_su, w_st, w_mu, w_mt;
    logic [3:0] w_done_cnt;
    logic [3:0] w_dec_su, w_dec_st, w_dec_mu, w_dec_mt;
    logic [3:0] w_norm_su, w_norm_st, w_norm_mu, w_norm_mt;
    logic       w_zero_time;
    logic       w_dec_zero;
    logic       w_key_ok;

    assign w_zero_time = (r_su == 4'd0) && (r_st == 4'd0) && (r_mu == 4'd0) && (r_mt == 4'd0);
    assign w_dec_zero  = (w_dec_su == 4'd0) && (w_dec_st == 4'd0) &&
                         (w_dec_mu == 4'd0) && (w_dec_mt == 4'd0);
    assign w_key_ok    = io_ctrl.key_valid && (io_ctrl.key_digit <= 4'd9);

    // One-second BCD decrement; seconds tens wraps 0->5. Never applied at 00:00.
    always_comb begin
        w_dec_su = r_su;
        w_dec_st = r_st;
        w_dec_mu = r_mu;
        w_dec_mt = r_mt;
        if (r_su != 4'd0) begin
            w_dec_su = r_su - 4'd1;
        end else begin
            w_dec_su = 4'd9;
            if (r_st != 4'd0) begin
                w_dec_st = r_st - 4'd1;
            end else begin
                w_dec_st = 4'd5;
                if (r_mu != 4'd0) begin
                    w_dec_mu = r_mu - 4'd1;
                end else begin
                    w_dec_mu = 4'd9;
                    w_dec_mt = r_mt - 4'd1;
                end
            end
        end
    end

    // Keypad entry allows SS up to 99; fold 60+ seconds into minutes, saturating at 99:59.
    always_comb begin
        w_norm_su = r_su;
        w_norm_st = r_st;
        w_norm_mu = r_mu;
        w_norm_mt = r_mt;
        if (r_st >= 4'd6) begin
            if ((r_mt == 4'd9) && (r_mu == 4'd9)) begin
                w_norm_st = 4'd5;
                w_norm_su = 4'd9;
            end else begin
                w_norm_st = r_st - 4'd6;
                if (r_mu == 4'd9) begin
                    w_norm_mu = 4'd0;
                    w_norm_mt = r_mt + 4'd1;
                end else begin
                    w_norm_mu = r_mu + 4'd1;
                end
            end
        end
    end

    // Only the highest-priority event acts: stop_clear > door_open > start > key_valid > tick.
    always_comb begin
        w_nstate   = r_state;
        w_su       = r_su;
        w_st       = r_st;
        w_mu       = r_mu;
        w_mt       = r_mt;
        w_done_cnt = r_done_cnt;
        case (r_state)
            S_IDLE, S_SET: begin
                if (io_ctrl.stop_clear) begin
                    w_nstate = S_IDLE;
                    w_su = 4'd0; w_st = 4'd0; w_mu = 4'd0; w_mt = 4'd0;
                end else if (io_ctrl.door_open) begin
                    w_nstate = r_state;
                end else if (io_ctrl.start) begin
                    w_nstate = S_RUN;
                    if (w_zero_time) begin
                        w_su = 4'd0; w_st = 4'd3; w_mu = 4'd0; w_mt = 4'd0;
                    end else begin
                        w_su = w_norm_su; w_st = w_norm_st;
                        w_mu = w_norm_mu; w_mt = w_norm_mt;
                    end
                end else if (io_ctrl.key_valid) begin
                    if (w_key_ok) begin
                        w_nstate = S_SET;
                        w_mt = r_mu;
                        w_mu = r_st;
                        w_st = r_su;
                        w_su = io_ctrl.key_digit;
                    end
                end
            end
            S_RUN: begin
                if (io_ctrl.stop_clear || io_ctrl.door_open) begin
                    w_nstate = S_PAUSE;
                end else if (io_ctrl.start || io_ctrl.key_valid) begin
                    w_nstate = S_RUN;
                end else if (io_ctrl.tick) begin
                    w_su = w_dec_su; w_st = w_dec_st;
                    w_mu = w_dec_mu; w_mt = w_dec_mt;
                    if (w_dec_zero) begin
                        w_nstate   = S_DONE;
                        w_done_cnt = LP_DONE_TICKS;
                    end
                end
            end
            S_PAUSE: begin
                if (io_ctrl.stop_clear) begin
                    w_nstate = S_IDLE;
                    w_su = 4'd0; w_st = 4'd0; w_mu = 4'd0; w_mt = 4'd0;
                end else if (io_ctrl.door_open) begin
                    w_nstate = S_PAUSE;
                end else if (io_ctrl.start) begin
                    w_nstate = S_RUN;
                end
            end
            S_DONE: begin
                if (io_ctrl.stop_clear || io_ctrl.door_open) begin
                    w_nstate   = S_IDLE;
                    w_done_cnt = 4'd0;
                end else if (io_ctrl.start || io_ctrl.key_valid) begin
                    w_nstate = S_DONE;
                end else if (io_ctrl.tick) begin
                    if (r_done_cnt <= 4'd1) begin
                        w_nstate   = S_IDLE;
                        w_done_cnt = 4'd0;
                    end else begin
                        w_done_cnt = r_done_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_nstate   = S_IDLE;
                w_su = 4'd0; w_st = 4'd0; w_mu = 4'd0; w_mt = 4'd0;
                w_done_cnt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_su       <= 4'd0;
            r_st       <= 4'd0;
            r_mu       <= 4'd0;
            r_mt       <= 4'd0;
            r_done_cnt <= 4'd0;
            r_mag      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_su       <= w_su;
            r_st       <= w_st;
            r_mu       <= w_mu;
            r_mt       <= w_mt;
            r_done_cnt <= w_done_cnt;
            r_mag      <= (w_nstate == S_RUN);
            r_done     <= (w_nstate == S_DONE);
        end
    end

    assign io_ctrl.sec_units    = r_su;
    assign io_ctrl.sec_tens     = r_st;
    assign io_ctrl.min_units    = r_mu;
    assign io_ctrl.min_tens     = r_mt;
    assign io_ctrl.magnetron_on = r_mag;
    assign io_ctrl.done         = r_done;
    assign io_ctrl.state        = r_state;

endmodule

// File: tb/tb_microondas_timer_ctrl.sv
// tb/tb_microondas_timer_ctrl.sv - scoreboard bench for the microwave countdown controller
module tb_microondas_timer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    microondas_timer_ctrl_if bus ();

    microondas_timer_ctrl #(.DONE_TICKS(3)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_ctrl (bus.slave)
    );

    always #5 clk = ~clk;

    // Word layout: {state[2:0], magnetron_on, done, MM:SS as four BCD digits}
    typedef struct {
        string       name;
        logic [20:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [20:0] obs_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [20:0] ev(logic [2:0] s, logic m, logic d, logic [15:0] mmss);
        return {s, m, d, mmss};
    endfunction

    function automatic logic [20:0] observe();
        return {bus.state, bus.magnetron_on, bus.done,
                bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
    endfunction

    task automatic push(string name, logic [20:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
        obs_q.push_back(observe());
    endtask

    task automatic step(logic t, logic kv, logic [3:0] kd, logic s, logic sc);
        bus.tick       = t;
        bus.key_valid  = kv;
        bus.key_digit  = kd;
        bus.start      = s;
        bus.stop_clear = sc;
        @(negedge clk);
        bus.tick       = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
    endtask

    task automatic key(logic [3:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_twice();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [20:0] o;
        push("reset_held", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        push("reset_released", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        logic [20:0] o;
        key(4'd1); key(4'd3); key(4'd0);
        push("keys_130", ev(3'd1, 1'b0, 1'b0, 16'h0130));
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("start_130", ev(3'd2, 1'b1, 1'b0, 16'h0130));
        ticks(1);
        push("tick_129", ev(3'd2, 1'b1, 1'b0, 16'h0129));
        ticks(88);
        push("tick_001", ev(3'd2, 1'b1, 1'b0, 16'h0001));
        ticks(1);
        push("enter_done", ev(3'd4, 1'b0, 1'b1, 16'h0000));
        ticks(2);
        push("done_held", ev(3'd4, 1'b0, 1'b1, 16'h0000));
        ticks(1);
        push("done_expired", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_normalize();
        exp_t e;
        logic [20:0] o;
        key(4'd9); key(4'd0);
        push("keys_090", ev(3'd1, 1'b0, 1'b0, 16'h0090));
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("norm_130", ev(3'd2, 1'b1, 1'b0, 16'h0130));
        clear_twice();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("clamp_9959", ev(3'd2, 1'b1, 1'b0, 16'h9959));
        clear_twice();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_borrow();
        exp_t e;
        logic [20:0] o;
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        ticks(1);
        push("borrow_0959", ev(3'd2, 1'b1, 1'b0, 16'h0959));
        clear_twice();
        key(4'd1); key(4'd0); key(4'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        ticks(1);
        push("borrow_0059", ev(3'd2, 1'b1, 1'b0, 16'h0059));
        clear_twice();
        push("cleared", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        exp_t e;
        logic [20:0] o;
        key(4'd4); key(4'd5);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("run_0045", ev(3'd2, 1'b1, 1'b0, 16'h0045));
        bus.door_open = 1'b1;
        ticks(1);
        push("door_with_tick", ev(3'd3, 1'b0, 1'b0, 16'h0045));
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("start_door_open", ev(3'd3, 1'b0, 1'b0, 16'h0045));
        bus.door_open = 1'b0;
        ticks(1);
        push("tick_in_pause", ev(3'd3, 1'b0, 1'b0, 16'h0045));
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("resume", ev(3'd2, 1'b1, 1'b0, 16'h0045));
        ticks(1);
        push("resume_tick", ev(3'd2, 1'b1, 1'b0, 16'h0044));
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        push("stop_pause", ev(3'd3, 1'b0, 1'b0, 16'h0044));
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        push("stop_clear", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_quick_start_priority();
        exp_t e;
        logic [20:0] o;
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("quick_start", ev(3'd2, 1'b1, 1'b0, 16'h0030));
        clear_twice();
        key(4'd12);
        push("bad_digit", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        key(4'd5);
        push("key_5", ev(3'd1, 1'b0, 1'b0, 16'h0005));
        step(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
        push("stop_wins", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [20:0] o;
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        push("start_with_tick", ev(3'd2, 1'b1, 1'b0, 16'h0030));
        ticks(29);
        push("run_0001", ev(3'd2, 1'b1, 1'b0, 16'h0001));
        ticks(1);
        push("done_30", ev(3'd4, 1'b0, 1'b1, 16'h0000));
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        push("done_abort", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        ticks(30);
        bus.door_open = 1'b1;
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        push("done_door", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        bus.door_open = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [20:0] o;
        key(4'd1); key(4'd2); key(4'd3);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        push("run_0123", ev(3'd2, 1'b1, 1'b0, 16'h0123));
        #2;
        rst = 1'b1;
        #1;
        push("async_reset", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        push("after_reset", ev(3'd0, 1'b0, 1'b0, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got {st,mag,done,mmss}=%h want %h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    initial begin
        bus.tick       = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
        bus.door_open  = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_countdown();
        test_normalize();
        test_borrow();
        test_pause();
        test_quick_start_priority();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/microondas_timer_ctrl.md
# microondas_timer_ctrl

Countdown controller for the microwave MM:SS timer: captures keypad digits, sequences the BCD minute/second countdown chain (seconds tens digit counts modulo 6) on a 1 Hz strobe, and gates the magnetron. It handles pause on door open, stop/clear, and quick start. It also raises a timed end-of-cook indication. It sits between the keypad/door inputs and the display and magnetron drivers.

## Interface
- DONE_TICKS, 3: number of `tick` strobes for which `done` stays high after countdown reaches 00:00 (1..15).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces reset state immediately.
- tick  in  1  one-cycle 1 Hz strobe, synchronous to clk.
- key_valid  in  1  one-cycle strobe: `key_digit` is valid.
- key_digit  in  4  BCD keypad digit; values >9 ignored.
- start  in  1  one-cycle start/resume strobe.
- stop_clear  in  1  one-cycle stop (first press) / clear strobe.
- door_open  in  1  level: door open.
- sec_units, sec_tens, min_units, min_tens  out  4 each  BCD time digits.
- magnetron_on  out  1  high only in RUN.
- done  out  1  high only in DONE.
- state  out  3  IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Reset: all digits 0, state IDLE, magnetron_on=0, done=0, internal done counter 0.
- Per-cycle priority: stop_clear > door_open > start > key_valid > tick; only the highest active event acts.
- IDLE/SET:
  - key_valid with digit ≤9 shifts the display left: min_tens←min_units, min_units←sec_tens, sec_tens←sec_units, sec_units←key_digit; → SET.
  - stop_clear clears digits; → IDLE.
  - start with door closed:
    - time 00:00 → load 00:30 and enter RUN (quick start).
    - otherwise normalize and enter RUN.
  - start with door open: ignored.
- Normalization at start: if SS ≥ 60, minutes += 1 and SS −= 60. If minutes were 99, clamp to 99:59.
- RUN:
  - tick decrements the time by one second with BCD borrow: sec_units 0→9 borrows from sec_tens, sec_tens 0→5 borrows from minutes, min_units 0→9 borrows from min_tens.
  - Decrement that produces 00:00 → DONE; done counter loaded with DONE_TICKS.
  - door_open or stop_clear → PAUSE with digits frozen.
- PAUSE:
  - start with door closed → RUN.
  - stop_clear clears digits → IDLE.
  - key_valid and tick ignored.
- DONE:
  - each tick decrements the done counter; reaching 0 → IDLE.
  - stop_clear or door_open → IDLE immediately.
  - digits stay 00:00.
- Invalid state encodings recover to IDLE with digits cleared.

## Timing
- All outputs registered; they change on the clk edge after the accepted event.
- reset acts asynchronously; outputs are valid at reset values while reset is high.
- magnetron_on rises 1 cycle after the accepted start and falls 1 cycle after door_open, stop_clear or the final decrement.
- A tick coincident with the accepted start is ignored; the first decrement uses the next tick.
- A tick coincident with door_open or stop_clear in RUN is discarded; no decrement occurs.
- Digits reach 00:00 on the same edge that enters DONE; done and magnetron_on never overlap.
- A countdown of N seconds needs N ticks after start; DONE lasts exactly DONE_TICKS ticks.
- door_open held high blocks start indefinitely; resuming requires a new start after closing.

## Test plan
- Reset mid-RUN at 01:23: assert reset asynchronously → digits 00:00, state 0, magnetron_on 0 before the next clk edge.
- Keys 1,3,0, start, door closed → digits 01:30; 1 cycle later magnetron_on=1; after 1 tick 01:29; after 90 ticks 00:00, done=1, magnetron_on=0; after 3 more ticks state IDLE, done=0.
- Keys 9,0 (00:90), start → normalized 01:30. Keys 9,9,9,9, start → 99:59.
- Borrow chain: start at 10:00, 1 tick → 09:59; at 01:00, 1 tick → 00:59.
- RUN at 00:45:
  - door_open together with tick → PAUSE, digits 00:45.
  - start while door open → no change.
  - close door, then start → RUN; next tick 00:44.
  - stop_clear → PAUSE; stop_clear again → IDLE, 00:00.
- IDLE at 00:00, start → 00:30, RUN. key_digit=12 in IDLE → ignored. start, key_valid and stop_clear in the same cycle → stop_clear wins, state IDLE.
